// File: rtl/handshake_seq_receiver.sv
// Valid/ready sink: drives a stall pattern on ready, checks for an incrementing data sequence and handshake rules.
// Optional macro HS_RX_LFSR_STALL_EN replaces the random_stall input with an internal 16-bit LFSR.
module handshake_seq_receiver #(
    parameter int              DW        = 8,
    parameter int              CW        = 16,
    parameter logic [DW-1:0]   INIT_VAL  = '0,
    parameter int              NUM_BEATS = 100,
    parameter logic [15:0]     LFSR_SEED = 16'hACE1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          random_stall,
    input  logic          valid_i,
    input  logic [DW-1:0] data_i,
    output logic          ready_o,
    output logic [CW-1:0] beat_cnt_o,
    output logic [CW-1:0] err_cnt_o,
    output logic          seq_err_o,
    output logic          proto_err_o,
    output logic [DW-1:0] first_exp_o,
    output logic [DW-1:0] first_got_o,
    output logic          done_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FAIL = 2'd2} state_t;

    state_t        state_q, state_n;
    logic [DW-1:0] exp_q;
    logic          pend_q;
    logic [DW-1:0] held_q;
    logic          stall;
    logic          xfer, mismatch, viol;

`ifdef HS_RX_LFSR_STALL_EN
    logic [15:0] lfsr_q;

    // Fibonacci taps 16,14,13,11; bit0 is the newest bit
    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= LFSR_SEED;
        else     lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    assign stall = lfsr_q[0];
`else
    assign stall = random_stall;
`endif

    assign xfer     = valid_i & ready_o;
    assign mismatch = xfer & (data_i != exp_q);
    // A beat offered while stalled must still be offered, unchanged, on the next edge
    assign viol     = pend_q & (~valid_i | (data_i != held_q));
    assign done_o   = (int'(beat_cnt_o) >= NUM_BEATS);

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_o     <= 1'b0;
            beat_cnt_o  <= '0;
            err_cnt_o   <= '0;
            seq_err_o   <= 1'b0;
            proto_err_o <= 1'b0;
            first_exp_o <= '0;
            first_got_o <= '0;
            exp_q       <= INIT_VAL;
            pend_q      <= 1'b0;
            held_q      <= '0;
        end else begin
            ready_o <= ~stall;
            pend_q  <= valid_i & ~ready_o;
            held_q  <= data_i;
            if (viol) proto_err_o <= 1'b1;
            if (xfer) begin
                if (beat_cnt_o != '1) beat_cnt_o <= beat_cnt_o + 1'b1;
                if (mismatch) begin
                    if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + 1'b1;
                    if (!seq_err_o) begin
                        first_exp_o <= exp_q;
                        first_got_o <= data_i;
                    end
                    seq_err_o <= 1'b1;
                    // Resync on the received value so one bad beat costs one error
                    exp_q     <= data_i + 1'b1;
                end else begin
                    exp_q <= exp_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:    if (mismatch | viol) state_n = FAIL;
                     else if (xfer)       state_n = RUN;
            RUN:     if (mismatch | viol) state_n = FAIL;
            FAIL:    state_n = FAIL;
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_handshake_seq_receiver.sv
// Scoreboard bench: a driver predicts each edge's outcome from a behavioural model and queues it; a monitor checks.
module tb_handshake_seq_receiver;
    localparam int DW = 8, CW = 8, INIT = 250, NB = 100, CMAX = 255;

    logic          clk = 1'b0, rst, random_stall, valid_i;
    logic [DW-1:0] data_i;
    logic          ready_o, seq_err_o, proto_err_o, done_o;
    logic [CW-1:0] beat_cnt_o, err_cnt_o;
    logic [DW-1:0] first_exp_o, first_got_o;

    handshake_seq_receiver #(.DW(DW), .CW(CW), .INIT_VAL(8'(INIT)), .NUM_BEATS(NB), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .rst(rst), .random_stall(random_stall), .valid_i(valid_i), .data_i(data_i),
        .ready_o(ready_o), .beat_cnt_o(beat_cnt_o), .err_cnt_o(err_cnt_o), .seq_err_o(seq_err_o),
        .proto_err_o(proto_err_o), .first_exp_o(first_exp_o), .first_got_o(first_got_o), .done_o(done_o));

    always #5 clk = ~clk;

    typedef struct {
        int ready, beats, errs, seq, proto, fexp, fgot, done;
    } exp_t;
    exp_t sb[$];

    int checks = 0, failures = 0;

    task automatic chk(input string n, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d t=%0t", n, got, want, $time);
        end
    endtask

    // Reference model state
    int m_ready, m_beats, m_errs, m_seq, m_proto, m_fexp, m_fgot, m_exp, m_pend, m_held, m_lfsr;
    bit last_acc;
    // Well-behaved source state
    bit src_v;
    int src_d, src_seq;

    task automatic step(input bit r, input bit st, input bit v, input int d);
        exp_t e;
        bit acc;
        int stall_used;
        rst = r; random_stall = st; valid_i = v; data_i = d[7:0];
        if (r) begin
            m_ready = 0; m_beats = 0; m_errs = 0; m_seq = 0; m_proto = 0;
            m_fexp = 0; m_fgot = 0; m_exp = INIT; m_pend = 0; m_held = 0;
            m_lfsr = 16'hACE1; last_acc = 0;
        end else begin
            acc = v && (m_ready != 0);
            if (m_pend != 0 && (!v || d != m_held)) m_proto = 1;
            m_pend = (v && m_ready == 0) ? 1 : 0;
            m_held = d;
            if (acc) begin
                m_beats = (m_beats < CMAX) ? m_beats + 1 : CMAX;
                if (d == m_exp) m_exp = (m_exp + 1) % 256;
                else begin
                    m_errs = (m_errs < CMAX) ? m_errs + 1 : CMAX;
                    if (m_seq == 0) begin m_fexp = m_exp; m_fgot = d; end
                    m_seq = 1;
                    m_exp = (d + 1) % 256;
                end
            end
`ifdef HS_RX_LFSR_STALL_EN
            stall_used = m_lfsr % 2;
`else
            stall_used = int'(st);
`endif
            m_ready = 1 - stall_used;
            m_lfsr = ((m_lfsr * 2) % 65536) +
                     (((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) % 2);
            last_acc = acc;
        end
        e.ready = m_ready; e.beats = m_beats; e.errs = m_errs; e.seq = m_seq;
        e.proto = m_proto; e.fexp = m_fexp; e.fgot = m_fgot; e.done = (m_beats >= NB) ? 1 : 0;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        repeat (n) step(1'b1, 1'b0, 1'b0, 0);
        src_v = 0; src_seq = INIT; src_d = 0;
    endtask

    // One cycle of an incrementing source; pbad/pviol inject bad data / handshake breaks (percent)
    task automatic src_cycle(input int pv, input int pbad, input int pviol, input bit st, input int prst);
        if ($urandom_range(0, 999) < prst) begin
            do_reset(1);
            return;
        end
        if (!src_v || last_acc) begin
            src_v = ($urandom_range(0, 99) < pv);
            if (src_v) begin
                src_d = ($urandom_range(0, 99) < pbad) ? (src_seq + 7) % 256 : src_seq;
                src_seq = (src_seq + 1) % 256;
            end
        end else if ($urandom_range(0, 99) < pviol) begin
            if ($urandom_range(0, 1) != 0) src_v = 0;
            else src_d = (src_d + 1) % 256;
        end
        step(1'b0, st, src_v, src_d);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("ready_o", int'(ready_o), e.ready);
                chk("beat_cnt", int'(beat_cnt_o), e.beats);
                chk("err_cnt", int'(err_cnt_o), e.errs);
                chk("seq_err", int'(seq_err_o), e.seq);
                chk("proto_err", int'(proto_err_o), e.proto);
                chk("first_exp", int'(first_exp_o), e.fexp);
                chk("first_got", int'(first_got_o), e.fgot);
                chk("done", int'(done_o), e.done);
            end
        end
    end

    initial begin : driver
        int bad_seq[5];
        rst = 1'b1; random_stall = 1'b0; valid_i = 1'b0; data_i = '0;
        src_v = 0; src_seq = INIT; src_d = 0; last_acc = 0;
        @(negedge clk);
        do_reset(3);

        // Back-to-back incrementing beats through the 255->0 wrap and past NUM_BEATS
        step(1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 120; i++) step(1'b0, 1'b0, 1'b1, (INIT + i) % 256);

        // Single out-of-sequence beat
        do_reset(1);
        step(1'b0, 1'b0, 1'b0, 0);
        bad_seq = '{250, 251, 252, 1, 2};
        foreach (bad_seq[i]) step(1'b0, 1'b0, 1'b1, bad_seq[i]);

        // Data changes while stalled
        do_reset(1);
        step(1'b0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 1'b0, 0);
        step(1'b0, 1'b1, 1'b1, 5);
        step(1'b0, 1'b0, 1'b1, 6);
        step(1'b0, 1'b0, 1'b0, 0);

        // Valid drops while stalled
        do_reset(1);
        step(1'b0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 1'b0, 0);
        step(1'b0, 1'b1, 1'b1, 5);
        step(1'b0, 1'b0, 1'b0, 5);

        // Alternating stall, clean source
        do_reset(1);
        for (int i = 0; i < 150; i++) src_cycle(100, 0, 0, 1'(i % 2), 0);

        // Long run with frequent bad data: counters reach saturation
        do_reset(1);
        for (int i = 0; i < 500; i++) src_cycle(90, 80, 0, ($urandom_range(0, 99) < 20), 0);

        // Random mix with handshake breaks and mid-burst resets
        do_reset(1);
        for (int i = 0; i < 600; i++)
            src_cycle(80, 3, 2, ($urandom_range(0, 99) < 30), 8);

        step(1'b0, 1'b0, 1'b0, 0);
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule
